seg7_scan_controller: RTL and testbench

- Time-multiplexes one 7-segment bus across NUM_DIGITS common-select digits; sits between the counting logic and the display pins.
- Accepts a packed BCD frame over a valid/ready handshake into a pending buffer; commits it only at a frame boundary, so a frame never tears.
- Scans digits with a dead-time (blank) interval between digits to stop ghosting.

---
 rtl/seg7_pkg.sv | 42 ++++
 rtl/seg7_scan_timer.sv | 44 ++++
 rtl/seg7_scan_controller.sv | 167 ++++++++++++++++
 tb/tb_seg7_scan_controller.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// ----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 7-segment scan controller.
//   - scan_state_t : scan FSM states (BLANK dead time, DRIVE one digit)
//   - BLANK_CODE   : BCD code that decodes to all segments off
//   - SEG_PATTERNS : segment patterns {a,b,c,d,e,f,g} (a = bit 6) per code
//   - seg_decode() : BCD nibble to active-high segment pattern
// ----------------------------------------------------------------------------
package seg7_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Entry 15 is listed first; codes 10..15 are not digits and stay dark.
    localparam logic [15:0][6:0] SEG_PATTERNS = {
        7'b0000000,  // 15
        7'b0000000,  // 14
        7'b0000000,  // 13
        7'b0000000,  // 12
        7'b0000000,  // 11
        7'b0000000,  // 10
        7'b1111011,  // 9
        7'b1111111,  // 8
        7'b1110000,  // 7
        7'b1011111,  // 6
        7'b1011011,  // 5
        7'b0110011,  // 4
        7'b1111001,  // 3
        7'b1101101,  // 2
        7'b0110000,  // 1
        7'b1111110   // 0
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] value);
        return SEG_PATTERNS[value];
    endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// ----------------------------------------------------------------------------
// seg7_scan_timer
// Phase timer for the scan FSM. Counts clocks spent in the current phase and
// raises phase_done during the last clock of that phase.
// Ports:
//   clk        in  system clock
//   reset      in  asynchronous active-high reset
//   in_blank   in  1 while the FSM is in BLANK, 0 while in DRIVE
//   phase_done out  combinational strobe, high in the final clock of a phase
// ----------------------------------------------------------------------------
module seg7_scan_timer #(
    parameter int DWELL_CYCLES = 16000,
    parameter int BLANK_CYCLES = 160
) (
    input  logic clk,
    input  logic reset,
    input  logic in_blank,
    output logic phase_done
);

    localparam int MAX_LEN = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    // With no dead time the only BLANK visit is the one out of reset; it lasts
    // a single clock so the scan starts as soon as possible.
    localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;

    logic [CNT_W-1:0] count;

    assign phase_done = (count == (in_blank ? BLANK_LAST : DWELL_LAST));

    // The counter restarts whenever a phase ends; phases only change then.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (phase_done) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/seg7_scan_controller.sv
// ----------------------------------------------------------------------------
// seg7_scan_controller
// Time-multiplexes one 7-segment bus across NUM_DIGITS common-select digits.
// A BCD frame is accepted into a pending buffer and only committed to the
// displayed (active) frame at a frame boundary, so a frame never tears.
// Each digit is preceded by BLANK_CYCLES of all-off dead time.
// Ports:
//   clk         in  system clock
//   reset       in  asynchronous active-high reset
//   digits_in   in  BCD frame, digit k at [4k+3:4k]
//   load_valid  in  frame offered
//   load_ready  out pending buffer empty
//   led_out     out segments {a,b,c,d,e,f,g}, active-high, registered
//   digit_sel   out one-hot digit enable, registered
//   frame_done  out one-clock pulse after each frame boundary
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN
//   When defined, zero digits above the most significant non-zero digit are
//   shown dark (digit 0 always shows).
// ----------------------------------------------------------------------------
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 16000,
    parameter int BLANK_CYCLES = 160
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load_valid,
    output logic                    load_ready,
    output logic [6:0]              led_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_ONE  = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    scan_state_t             state;
    scan_state_t             state_next;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        idx_next;
    logic [4*NUM_DIGITS-1:0] active;
    logic [4*NUM_DIGITS-1:0] active_next;
    logic [4*NUM_DIGITS-1:0] pending;
    logic                    pending_full;
    logic                    phase_done;
    logic                    boundary;
    logic                    commit;
    logic [6:0]              led_next;
    logic [NUM_DIGITS-1:0]   sel_next;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [NUM_DIGITS-1:0]   blank_mask_next;

    // Walk down from the top digit; everything until the first non-zero
    // digit is a leading zero. Digit 0 is never part of the mask.
    function automatic logic [NUM_DIGITS-1:0] leading_zero_mask(input logic [4*NUM_DIGITS-1:0] frame);
        logic [NUM_DIGITS-1:0] mask;
        logic                  seen_nonzero;
        mask         = '0;
        seen_nonzero = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (frame[4*k +: 4] != 4'd0) begin
                seen_nonzero = 1'b1;
            end
            mask[k] = !seen_nonzero;
        end
        return mask;
    endfunction
`endif

    seg7_scan_timer #(
        .DWELL_CYCLES (DWELL_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .in_blank   (state == BLANK),
        .phase_done (phase_done)
    );

    // The buffer flag is itself a flop, so ready comes straight off a register.
    assign load_ready = !pending_full;

    // Next state, scan index and frame commit.
    always_comb begin
        state_next  = state;
        idx_next    = idx;
        boundary    = 1'b0;
        if (phase_done) begin
            if (state == BLANK) begin
                state_next = DRIVE;
            end else begin
                boundary   = (idx == LAST_IDX);
                idx_next   = boundary ? '0 : idx + 1'b1;
                state_next = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
            end
        end
        commit      = boundary && pending_full;
        active_next = commit ? pending : active;
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    always_comb begin
        blank_mask_next = commit ? leading_zero_mask(pending) : blank_mask;
    end
`endif

    // Outputs are computed from the next state so the registered pins change
    // on the same edge as the FSM and cannot glitch.
    always_comb begin
        sel_next = '0;
        led_next = '0;
        if (state_next == DRIVE) begin
            sel_next = SEL_ONE << idx_next;
            led_next = seg_decode(active_next[4*idx_next +: 4]);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            if (blank_mask_next[idx_next]) begin
                led_next = '0;
            end
`endif
        end
    end

    // State, frame buffers and registered outputs. A commit and a transfer
    // can never coincide since a full buffer holds ready low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= BLANK;
            idx          <= '0;
            active       <= {NUM_DIGITS{BLANK_CODE}};
            pending      <= '0;
            pending_full <= 1'b0;
            led_out      <= '0;
            digit_sel    <= '0;
            frame_done   <= 1'b0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            active     <= active_next;
            led_out    <= led_next;
            digit_sel  <= sel_next;
            frame_done <= boundary;
            if (commit) begin
                pending_full <= 1'b0;
            end else if (load_valid && !pending_full) begin
                pending      <= digits_in;
                pending_full <= 1'b1;
            end
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blank_mask <= '0;
        end else begin
            blank_mask <= blank_mask_next;
        end
    end
`endif

endmodule

// File: tb/tb_seg7_scan_controller.sv
// ----------------------------------------------------------------------------
// tb_seg7_scan_controller
// Self-checking bench for seg7_scan_controller (4 digits, dwell 8, blank 2).
// A reference model tracks the displayed frame, the pending buffer and the
// position inside the 40-clock frame; every clock all outputs are compared.
// Honours SEG7_LEADING_ZERO_BLANK_EN when defined.
// ----------------------------------------------------------------------------
module tb_seg7_scan_controller;

    localparam int ND    = 4;
    localparam int DW    = 8;
    localparam int BL    = 2;
    localparam int SLOT  = DW + BL;
    localparam int FRAME = ND * SLOT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] digits_in = '0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [6:0]  led_out;
    logic [3:0]  digit_sel;
    logic        frame_done;

    seg7_scan_controller #(
        .NUM_DIGITS   (ND),
        .DWELL_CYCLES (DW),
        .BLANK_CYCLES (BL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digits_in  (digits_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .led_out    (led_out),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]      frame;
        logic [3:0][6:0]  exp_led;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;

    int          m_p;
    bit          m_pend_full;
    logic [15:0] m_pending;
    int          m_active [ND];
    bit          m_mask [ND];

    logic        drv_valid = 1'b0;
    logic [15:0] drv_data  = '0;

    vec_t        vectors [$];

    function automatic logic [6:0] ref_decode(input int v);
        case (v)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_p         = 0;
        m_pend_full = 1'b0;
        m_pending   = '0;
        for (int k = 0; k < ND; k++) begin
            m_active[k] = 15;
            m_mask[k]   = 1'b0;
        end
    endtask

    task automatic modelCommit();
        int msd;
        msd = 0;
        for (int k = 0; k < ND; k++) begin
            m_active[k] = int'(m_pending[4*k +: 4]);
            m_mask[k]   = 1'b0;
            if (m_active[k] != 0) msd = k;
        end
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        for (int k = 0; k < ND; k++) begin
            m_mask[k] = (k > msd);
        end
`endif
    endtask

    task automatic checkCycle();
        int          pos;
        int          d;
        int          w;
        logic [31:0] exp_sel;
        logic [31:0] exp_led;
        pos = m_p % FRAME;
        d   = pos / SLOT;
        w   = pos % SLOT;
        if (w < BL) begin
            exp_sel = 0;
            exp_led = 0;
        end else begin
            exp_sel = 32'(1) << d;
            exp_led = m_mask[d] ? 32'(0) : 32'(ref_decode(m_active[d]));
        end
        checkOutput($sformatf("digit_sel p=%0d", m_p), 32'(digit_sel), exp_sel);
        checkOutput($sformatf("led_out p=%0d", m_p), 32'(led_out), exp_led);
        checkOutput($sformatf("frame_done p=%0d", m_p), 32'(frame_done), 32'(pos == 0 && m_p > 0));
        checkOutput($sformatf("load_ready p=%0d", m_p), 32'(load_ready), 32'(!m_pend_full));
    endtask

    // One clock: check the current interval, drive inputs, predict the edge.
    task automatic applyStimulus();
        bit was_full;
        checkCycle();
        load_valid = drv_valid;
        digits_in  = drv_data;
        was_full   = m_pend_full;
        if (((m_p + 1) % FRAME == 0) && was_full) begin
            modelCommit();
            m_pend_full = 1'b0;
        end
        if (drv_valid && !was_full) begin
            m_pending   = drv_data;
            m_pend_full = 1'b1;
        end
        m_p++;
        @(negedge clk);
    endtask

    task automatic runUntilPos(input int target);
        for (int i = 0; i < 2 * FRAME && (m_p % FRAME) != target; i++) begin
            applyStimulus();
        end
        checkOutput("reached_pos", 32'(m_p % FRAME), 32'(target));
    endtask

    task automatic loadFrame(input logic [15:0] frame);
        bit accepted;
        accepted  = 1'b0;
        drv_valid = 1'b1;
        drv_data  = frame;
        for (int i = 0; i < 3 * FRAME && !accepted; i++) begin
            accepted = !m_pend_full;
            applyStimulus();
        end
        drv_valid = 1'b0;
        checkOutput("load_accepted", 32'(accepted), 32'(1));
    endtask

    task automatic waitCommit();
        for (int i = 0; i < 3 * FRAME && m_pend_full; i++) begin
            applyStimulus();
        end
        checkOutput("commit_reached", 32'(m_pend_full), 32'(0));
    endtask

    task automatic checkFrameDigits(input string tag, input logic [3:0][6:0] exp_led);
        for (int d = 0; d < ND; d++) begin
            runUntilPos(d * SLOT + BL + 3);
            checkOutput($sformatf("%s led d%0d", tag, d), 32'(led_out), 32'(exp_led[d]));
            checkOutput($sformatf("%s sel d%0d", tag, d), 32'(digit_sel), 32'(1) << d);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;

        v.frame = 16'h1234; v.exp_led = {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}; vectors.push_back(v);
        v.frame = 16'h9A80; v.exp_led = {7'b1111011, 7'b0000000, 7'b1111111, 7'b1111110}; vectors.push_back(v);
        v.frame = 16'h5670; v.exp_led = {7'b1011011, 7'b1011111, 7'b1110000, 7'b1111110}; vectors.push_back(v);
        v.frame = 16'hFFFF; v.exp_led = {7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000}; vectors.push_back(v);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        v.frame = 16'h0050; v.exp_led = {7'b0000000, 7'b0000000, 7'b1011011, 7'b1111110}; vectors.push_back(v);
        v.frame = 16'h0000; v.exp_led = {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}; vectors.push_back(v);
`else
        v.frame = 16'h0050; v.exp_led = {7'b1111110, 7'b1111110, 7'b1011011, 7'b1111110}; vectors.push_back(v);
`endif

        // Reset state while reset is held.
        modelReset();
        #2;
        checkOutput("rst led_out", 32'(led_out), 32'(0));
        checkOutput("rst digit_sel", 32'(digit_sel), 32'(0));
        checkOutput("rst frame_done", 32'(frame_done), 32'(0));
        checkOutput("rst load_ready", 32'(load_ready), 32'(1));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelReset();

        $display("[TB] idle scan with blank frame");
        repeat (FRAME + 5) applyStimulus();

        $display("[TB] single load mid-frame");
        runUntilPos(15);
        loadFrame(16'h1234);
        checkOutput("ready_low_while_pending", 32'(load_ready), 32'(0));
        waitCommit();
        repeat (FRAME) applyStimulus();

        $display("[TB] back-to-back loads");
        loadFrame(16'h4444);
        loadFrame(16'h7777);
        checkFrameDigits("b2b_first", {4{7'b0110011}});
        waitCommit();
        checkFrameDigits("b2b_second", {4{7'b1110000}});

        $display("[TB] decode vector table");
        foreach (vectors[i]) begin
            loadFrame(vectors[i].frame);
            waitCommit();
            checkFrameDigits($sformatf("vec%0d", i), vectors[i].exp_led);
        end

        $display("[TB] randomized traffic");
        for (int i = 0; i < 800; i++) begin
            drv_valid = ($urandom_range(0, 5) == 0);
            drv_data  = 16'($urandom);
            applyStimulus();
        end
        drv_valid = 1'b0;
        waitCommit();

        $display("[TB] reset during DRIVE of digit 2");
        runUntilPos(10);
        loadFrame(16'h1234);
        runUntilPos(24);
        checkCycle();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_rst led_out", 32'(led_out), 32'(0));
        checkOutput("async_rst digit_sel", 32'(digit_sel), 32'(0));
        checkOutput("async_rst frame_done", 32'(frame_done), 32'(0));
        checkOutput("async_rst load_ready", 32'(load_ready), 32'(1));
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        repeat (2 * FRAME + 3) applyStimulus();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
